// File: rtl/lns_delugish_log.sv
// Iterative De Lugish linear-to-log converter: log2(1.f) computed by greedy
// shift-add factoring of the mantissa, one factor (1+2^-n) per clock.
module lns_delugish_log #(
  parameter int Y_BITS = 8,
  parameter int X_BITS = 8,
  parameter int I      = 12,
  parameter int L_BITS = 16,
  parameter int E_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in_valid,
  output logic              data_in_enable,
  input  logic [Y_BITS-1:0] data_in,
  output logic              data_out_valid,
  input  logic              data_out_enable,
  output logic [X_BITS-1:0] data_out
);

  localparam int N_W = $clog2(I + 1);
  localparam int PAD = E_BITS - Y_BITS;
  localparam logic [E_BITS:0] E_ONE = (E_BITS + 1)'(1) << E_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // log2(1+2^-n) as a 32-bit fraction (16 significant bits), top L_BITS returned
  function automatic logic [L_BITS-1:0] log_const(input logic [N_W-1:0] n);
    logic [31:0] v;
    case (int'(n))
      1:       v = {16'd38336, 16'd0};
      2:       v = {16'd21098, 16'd0};
      3:       v = {16'd11136, 16'd0};
      4:       v = {16'd5732,  16'd0};
      5:       v = {16'd2909,  16'd0};
      6:       v = {16'd1466,  16'd0};
      7:       v = {16'd736,   16'd0};
      8:       v = {16'd369,   16'd0};
      9:       v = {16'd184,   16'd0};
      10:      v = {16'd92,    16'd0};
      11:      v = {16'd46,    16'd0};
      12:      v = {16'd23,    16'd0};
      13:      v = {16'd12,    16'd0};
      14:      v = {16'd6,     16'd0};
      15:      v = {16'd3,     16'd0};
      16:      v = {16'd1,     16'd0};
      default: v = 32'd0;
    endcase
    return L_BITS'(v >> (32 - L_BITS));
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic [E_BITS:0]     r_m;
  logic [E_BITS:0]     r_e;
  logic [L_BITS:0]     r_l;
  logic [N_W-1:0]      r_n;
  logic                r_valid;
  logic [X_BITS-1:0]   r_dout;

  logic                w_accept;
  logic                w_last;
  logic [E_BITS:0]     w_m_load;
  logic [E_BITS+1:0]   w_cand;
  logic                w_take;
  logic [E_BITS:0]     w_e_next;
  logic [L_BITS-1:0]   w_const;
  logic [L_BITS:0]     w_l_next;
  logic [X_BITS:0]     w_round_top;
  logic                w_sat;
  logic [X_BITS-1:0]   w_dout_next;

  assign data_in_enable = !rst & ((r_state == S_IDLE) |
                                  ((r_state == S_DONE) & data_out_enable));
  assign w_accept       = data_in_valid & data_in_enable;
  assign w_last         = (r_n == N_W'(I));
  assign w_m_load       = (E_BITS + 1)'({1'b1, data_in}) << PAD;

  // Extra top bit on the candidate keeps E + E/2 from wrapping before the compare
  assign w_cand   = {1'b0, r_e} + ({1'b0, r_e} >> r_n);
  assign w_take   = (w_cand <= {1'b0, r_m});
  assign w_e_next = w_take ? w_cand[E_BITS:0] : r_e;
  assign w_const  = log_const(r_n);
  assign w_l_next = w_take ? (r_l + {1'b0, w_const}) : r_l;

  // Round half up on the top X_BITS fraction bits; integer bit or carry saturates
  assign w_round_top = {1'b0, w_l_next[L_BITS-1 -: X_BITS]} +
                       (X_BITS + 1)'(w_l_next[L_BITS-X_BITS-1]);
  assign w_sat       = w_l_next[L_BITS] | w_round_top[X_BITS];
  assign w_dout_next = w_sat ? {X_BITS{1'b1}} : w_round_top[X_BITS-1:0];

  assign data_out_valid = r_valid;
  assign data_out       = r_dout;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
        else        w_state_next = S_RUN;
      end
      S_DONE: begin
        if (data_out_enable) begin
          if (w_accept) w_state_next = S_RUN;
          else          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand load, iteration datapath and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m     <= '0;
      r_e     <= '0;
      r_l     <= '0;
      r_n     <= '0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if ((r_state == S_DONE) && data_out_enable) r_valid <= 1'b0;
          if (w_accept) begin
            r_m <= w_m_load;
            r_e <= E_ONE;
            r_l <= '0;
            r_n <= N_W'(1);
          end
        end
        S_RUN: begin
          r_e <= w_e_next;
          r_l <= w_l_next;
          r_n <= r_n + N_W'(1);
          if (w_last) begin
            r_valid <= 1'b1;
            r_dout  <= w_dout_next;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lns_delugish_log.sv
// Directed bench for lns_delugish_log (X_BITS = Y_BITS = 8, I = 12): latency,
// accuracy against a real-valued log2 model, backpressure, reset abort, full sweep.
module tb_lns_delugish_log;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in_valid;
  logic       data_in_enable;
  logic [7:0] data_in;
  logic       data_out_valid;
  logic       data_out_enable;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  lns_delugish_log #(
    .Y_BITS(8), .X_BITS(8), .I(12), .L_BITS(16), .E_BITS(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .data_in_enable (data_in_enable),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out_enable(data_out_enable),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    n_checks++;
    assert ((obs <= exp + 1) && (obs + 1 >= exp)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
  endtask

  function automatic int ref_log(input int f);
    real m;
    real l;
    int  r;
    m = 1.0 + real'(f) / 256.0;
    l = $ln(m) / $ln(2.0) * 256.0;
    r = $rtoi(l + 0.5);
    if (r > 255) r = 255;
    return r;
  endfunction

  // Accept one operand, then count cycles until the result shows up
  task automatic run_op(input logic [7:0] f, output int lat);
    int w;
    w = 0;
    while (!data_in_enable && w < 40) begin
      tick();
      w++;
    end
    check("ready_for_op", data_in_enable, 1);
    data_in       = f;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    check("enable_low_in_run", data_in_enable, 0);
    lat = 0;
    while (!data_out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    data_out_enable = 1'b1;
    tick();
    data_out_enable = 1'b0;
    check("valid_falls", data_out_valid, 0);
  endtask

  initial begin
    int lat;
    int cyc;
    int got;
    int idx;
    int last_cyc;
    bit acc;
    logic [7:0] held;
    logic [7:0] q[$];

    rst             = 1'b1;
    data_in_valid   = 1'b0;
    data_in         = 8'h00;
    data_out_enable = 1'b0;
    #2;
    tick();
    tick();
    check("rst_valid", data_out_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_in_enable", data_in_enable, 0);
    rst = 1'b0;
    #1;
    check("release_in_enable", data_in_enable, 1);

    // Zero input: exact zero, latency I
    run_op(8'h00, lat);
    check("lat_00", lat, 12);
    check("dout_00", data_out, 8'h00);
    consume();

    run_op(8'h40, lat);
    check("lat_40", lat, 12);
    check_near("dout_40", int'(data_out), 8'h52);
    consume();

    run_op(8'hFF, lat);
    check("lat_FF", lat, 12);
    check("dout_FF_sat", data_out, 8'hFF);
    consume();

    // 0x80 followed by five cycles of backpressure
    run_op(8'h80, lat);
    check("lat_80", lat, 12);
    check_near("dout_80", int'(data_out), 8'h96);
    held = data_out;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", data_out, held);
      check("bp_hold_valid", data_out_valid, 1);
      check("bp_in_enable", data_in_enable, 0);
    end
    data_in         = 8'h40;
    data_in_valid   = 1'b1;
    data_out_enable = 1'b1;
    #1;
    check("bp_release_enable", data_in_enable, 1);
    tick();
    data_in_valid   = 1'b0;
    data_out_enable = 1'b0;
    check("bp_valid_falls", data_out_valid, 0);
    check("bp_next_running", data_in_enable, 0);
    lat = 0;
    while (!data_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("bp_next_lat", lat, 12);
    check_near("bp_next_dout", int'(data_out), 8'h52);
    consume();

    // Reset in the sixth RUN cycle discards the operation
    data_in       = 8'h80;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("midrun_rst_valid", data_out_valid, 0);
    check("midrun_rst_dout", data_out, 0);
    check("midrun_rst_in_enable", data_in_enable, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("midrun_release_enable", data_in_enable, 1);
    run_op(8'h80, lat);
    check("after_rst_lat", lat, 12);
    check_near("after_rst_dout", int'(data_out), 8'h96);
    consume();

    // Back-to-back sweep of every input with data_out_enable held high
    idx             = 0;
    got             = 0;
    cyc             = 0;
    last_cyc        = -1;
    data_in         = 8'h00;
    data_in_valid   = 1'b1;
    data_out_enable = 1'b1;
    while (got < 256 && cyc < 4000) begin
      acc = data_in_valid && data_in_enable;
      if (acc) q.push_back(data_in);
      tick();
      cyc++;
      if (data_out_valid) begin
        if (q.size() == 0) begin
          check("sweep_unexpected_result", 1, 0);
        end else begin
          held = q.pop_front();
          check_near($sformatf("sweep_%02h", held), int'(data_out), ref_log(int'(held)));
        end
        if (last_cyc >= 0) check("sweep_spacing", cyc - last_cyc, 13);
        last_cyc = cyc;
        got++;
      end
      if (acc) begin
        idx++;
        if (idx < 256) data_in = idx[7:0];
        else           data_in_valid = 1'b0;
      end
    end
    check("sweep_count", got, 256);
    data_out_enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
